// File: rtl/sys_arr_os.sv
// Output-stationary systolic matrix-multiply array: C[r][c] = sum_k A[k][r]*W[k][c].
// Operands stream in on a valid/ready port, results drain row by row with backpressure.
module sys_arr_os #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KW   = 16,
  localparam int IW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 sgn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_a,
  input  logic [COLS*DW-1:0]   in_w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*AW-1:0]   out_row,
  output logic [IW-1:0]        out_idx,
  output logic                 busy,
  output logic                 done
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | accepting k_len input beats
  // FLUSH | pushing zeros until the last beat reaches PE(ROWS-1,COLS-1)
  // DRAIN | presenting one accumulator row per handshake
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  localparam int FL = ROWS + COLS - 2;
  localparam int FW = (FL > 1) ? $clog2(FL) : 1;

  state_t        state;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic          sgn_q;
  logic          clr;
  logic          step;

  logic [DW-1:0]      a_h [ROWS][COLS];
  logic [DW-1:0]      w_h [ROWS][COLS];
  logic [COLS*AW-1:0] acc_row [ROWS];

  assign clr  = (state == IDLE) && start;
  // in_ready is high exactly while in LOAD
  assign step = (in_ready && in_valid) || (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_lat     <= '0;
      cnt       <= '0;
      fcnt      <= '0;
      sgn_q     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            k_lat <= k_len;
            sgn_q <= sgn;
            cnt   <= '0;
            fcnt  <= '0;
            busy  <= 1'b1;
            if (k_len != '0) begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end else begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            cnt <= cnt + KW'(1);
            if (cnt == k_lat - KW'(1)) begin
              in_ready <= 1'b0;
              if (FL == 0) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == FW'(FL - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_idx == IW'(ROWS - 1)) begin
              state     <= IDLE;
              out_idx   <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx <= out_idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input skew: lane r sees beat s-r at step s; zeros are injected outside LOAD.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [DW-1:0] a_inj;
    assign a_inj = in_ready ? in_a[r*DW +: DW] : '0;
    if (r == 0) begin : g_nodly
      assign a_h[0][0] = a_inj;
    end else begin : g_dly
      logic [DW-1:0] sh [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int i = 0; i < r; i++) sh[i] <= '0;
        end else if (step) begin
          sh[0] <= a_inj;
          for (int i = 1; i < r; i++) sh[i] <= sh[i-1];
        end
      end
      assign a_h[r][0] = sh[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    logic [DW-1:0] w_inj;
    assign w_inj = in_ready ? in_w[c*DW +: DW] : '0;
    if (c == 0) begin : g_nodly
      assign w_h[0][0] = w_inj;
    end else begin : g_dly
      logic [DW-1:0] sh [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int i = 0; i < c; i++) sh[i] <= '0;
        end else if (step) begin
          sh[0] <= w_inj;
          for (int i = 1; i < c; i++) sh[i] <= sh[i-1];
        end
      end
      assign w_h[0][c] = sh[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic [2*DW-1:0] ax, wx, prod;
      logic [AW-1:0]   prod_x, acc_q;

      assign ax     = sgn_q ? {{DW{a_h[r][c][DW-1]}}, a_h[r][c]} : {{DW{1'b0}}, a_h[r][c]};
      assign wx     = sgn_q ? {{DW{w_h[r][c][DW-1]}}, w_h[r][c]} : {{DW{1'b0}}, w_h[r][c]};
      assign prod   = ax * wx;
      assign prod_x = sgn_q ? AW'($signed(prod)) : AW'(prod);

      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) acc_q <= '0;
        else if (step)  acc_q <= acc_q + prod_x;
      end
      assign acc_row[r][c*AW +: AW] = acc_q;

      if (c < COLS - 1) begin : g_apipe
        logic [DW-1:0] a_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst || clr) a_q <= '0;
          else if (step)  a_q <= a_h[r][c];
        end
        assign a_h[r][c+1] = a_q;
      end

      if (r < ROWS - 1) begin : g_wpipe
        logic [DW-1:0] w_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst || clr) w_q <= '0;
          else if (step)  w_q <= w_h[r][c];
        end
        assign w_h[r+1][c] = w_q;
      end
    end
  end

  // Accumulators hold during DRAIN, so the row mux output is stable under backpressure.
  always_comb begin
    out_row = '0;
    if (out_valid) out_row = acc_row[out_idx];
  end

endmodule

// File: tb/tb_sys_arr_os.sv
// Bench for sys_arr_os: table-driven fill jobs, scoreboarded drains, and hand-written
// corner sequences (stall, k_len=0, async reset, ignored start, 2x3 instance).
module tb_sys_arr_os;

  localparam int R = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, sgn, in_valid, out_ready;
  logic [15:0]  k_len;
  logic [31:0]  in_a, in_w;
  logic         in_ready, out_valid, busy, done;
  logic [127:0] out_row;
  logic [1:0]   out_idx;

  logic         b_start, b_sgn, b_in_valid, b_out_ready;
  logic [15:0]  b_k_len;
  logic [15:0]  b_in_a;
  logic [23:0]  b_in_w;
  logic         b_in_ready, b_out_valid, b_busy, b_done;
  logic [95:0]  b_out_row;
  logic [0:0]   b_out_idx;

  sys_arr_os #(.ROWS(4), .COLS(4), .DW(8), .AW(32), .KW(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .sgn(sgn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  sys_arr_os #(.ROWS(2), .COLS(3), .DW(8), .AW(32), .KW(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(b_start), .k_len(b_k_len), .sgn(b_sgn),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_w(b_in_w),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
    .out_idx(b_out_idx), .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0]   am [8][4];
  logic [7:0]   wm [8][4];
  logic [127:0] exp_q  [$];

  typedef struct {
    int          k;
    bit          s;
    logic [7:0]  a;
    logic [7:0]  w;
    logic [31:0] c;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] model_c(input int k, input bit s, input int r, input int c);
    longint acc, av, wv;
    acc = 0;
    for (int kk = 0; kk < k; kk++) begin
      av = s ? longint'($signed(am[kk][r])) : longint'(am[kk][r]);
      wv = s ? longint'($signed(wm[kk][c])) : longint'(wm[kk][c]);
      acc += av * wv;
    end
    return acc[31:0];
  endfunction

  task automatic push_model(input int k, input bit s);
    logic [127:0] row;
    for (int r = 0; r < R; r++) begin
      row = '0;
      for (int c = 0; c < C; c++) row[c*32 +: 32] = model_c(k, s, r, c);
      exp_q.push_back(row);
    end
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int l = 0; l < 4; l++) begin
        am[kk][l] = 8'($urandom_range(0, 255));
        wm[kk][l] = 8'($urandom_range(0, 255));
      end
  endtask

  task automatic run_job(input int k, input bit s, input bit gap, input int stall,
                         input bit chk_lat, input bit poke);
    int beat, n, hs_cyc;
    bit tog, hs, moved;
    logic [127:0] snap, expv;
    logic [1:0]   sidx;
    out_ready = (stall == 0);
    @(negedge clk);
    start = 1'b1; k_len = 16'(k); sgn = s;
    @(negedge clk);
    start = 1'b0;
    if (k == 0) chk("k0_in_ready", 128'(in_ready), 128'(0));
    beat = 0; n = 0; tog = 1'b1; hs_cyc = 0;
    while (beat < k && n < 200) begin
      in_valid = gap ? tog : 1'b1;
      tog = ~tog;
      for (int l = 0; l < 4; l++) begin
        in_a[l*8 +: 8] = am[beat][l];
        in_w[l*8 +: 8] = wm[beat][l];
      end
      hs = in_valid && in_ready;
      if (hs) hs_cyc = cyc;
      @(negedge clk);
      if (hs) beat++;
      n++;
    end
    in_valid = 1'b0;
    if (beat < k) chk("load_timeout", 128'(beat), 128'(k));
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int row = 0; row < R; row++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) begin
        chk("drain_timeout", 128'(out_valid), 128'(1));
        return;
      end
      if (row == 0 && chk_lat) chk("latency", 128'(cyc - hs_cyc), 128'(R + C - 1));
      snap = out_row; sidx = out_idx; moved = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (out_row !== snap || out_idx !== sidx || !out_valid) moved = 1'b1;
      end
      if (stall > 0) chk("stall_stable", 128'(moved), 128'(0));
      chk("row_idx", 128'(out_idx), 128'(row));
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      chk("row_data", out_row, expv);
      out_ready = 1'b1;
      if (poke && row == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = (stall == 0);
    end
    chk("done_pulse", 128'(done), 128'(1));
    chk("busy_after", 128'(busy), 128'(0));
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_once", 128'(done), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] row;
    logic [95:0]  row2;
    int n, beat;
    bit hs;

    tbl[0] = '{k: 2, s: 1'b1, a: 8'hFF, w: 8'd127, c: 32'hFFFFFF02};
    tbl[1] = '{k: 2, s: 1'b0, a: 8'hFF, w: 8'd127, c: 32'd64770};
    tbl[2] = '{k: 3, s: 1'b1, a: 8'h80, w: 8'h80, c: 32'd49152};
    tbl[3] = '{k: 1, s: 1'b1, a: 8'h80, w: 8'h7F, c: 32'hFFFFC080};
    tbl[4] = '{k: 4, s: 1'b0, a: 8'hFF, w: 8'hFF, c: 32'd260100};

    rst = 1'b1; start = 1'b0; sgn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; in_a = '0; in_w = '0;
    b_start = 1'b0; b_sgn = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_k_len = '0; b_in_a = '0; b_in_w = '0;
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_out_idx", 128'(out_idx), 128'(0));
    chk("rst_out_row", out_row, 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // identity A: drained rows equal the W rows
    for (int kk = 0; kk < 4; kk++)
      for (int l = 0; l < 4; l++) begin
        am[kk][l] = (kk == l) ? 8'd1 : 8'd0;
        wm[kk][l] = 8'(4 * kk + l + 1);
      end
    for (int r = 0; r < R; r++) begin
      row = '0;
      for (int c = 0; c < C; c++) row[c*32 +: 32] = 32'(4 * r + c + 1);
      exp_q.push_back(row);
    end
    run_job(4, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    for (int t = 0; t < 5; t++) begin
      for (int kk = 0; kk < tbl[t].k; kk++)
        for (int l = 0; l < 4; l++) begin
          am[kk][l] = tbl[t].a;
          wm[kk][l] = tbl[t].w;
        end
      for (int r = 0; r < R; r++) exp_q.push_back({4{tbl[t].c}});
      run_job(tbl[t].k, tbl[t].s, 1'b0, 0, 1'b0, 1'b0);
    end

    // same data unstalled, then with input gaps and output backpressure
    fill_rand(5);
    push_model(5, 1'b1);
    run_job(5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    push_model(5, 1'b1);
    run_job(5, 1'b1, 1'b1, 3, 1'b0, 1'b0);

    for (int r = 0; r < R; r++) exp_q.push_back(128'(0));
    run_job(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // async reset in the middle of LOAD
    fill_rand(4);
    @(negedge clk);
    start = 1'b1; k_len = 16'd4; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int l = 0; l < 4; l++) begin
        in_a[l*8 +: 8] = am[b][l];
        in_w[l*8 +: 8] = wm[b][l];
      end
      @(negedge clk);
    end
    chk("busy_pre_rst", 128'(busy), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_out_idx", 128'(out_idx), 128'(0));
    chk("arst_out_row", out_row, 128'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fill_rand(4);
    push_model(4, 1'b0);
    run_job(4, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // start pulsed during FLUSH and DRAIN must not disturb the job
    fill_rand(3);
    push_model(3, 1'b1);
    run_job(3, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("poke_idle", 128'(busy), 128'(0));

    // 2x3 instance against the reference model
    fill_rand(5);
    @(negedge clk);
    b_start = 1'b1; b_k_len = 16'd5; b_sgn = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    beat = 0; n = 0;
    while (beat < 5 && n < 100) begin
      b_in_valid = 1'b1;
      for (int l = 0; l < 2; l++) b_in_a[l*8 +: 8] = am[beat][l];
      for (int l = 0; l < 3; l++) b_in_w[l*8 +: 8] = wm[beat][l];
      hs = b_in_ready;
      @(negedge clk);
      if (hs) beat++;
      n++;
    end
    b_in_valid = 1'b0;
    chk("b_beats", 128'(beat), 128'(5));
    b_out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (!b_out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("b_out_valid", 128'(b_out_valid), 128'(1));
      row2 = '0;
      for (int c = 0; c < 3; c++) row2[c*32 +: 32] = model_c(5, 1'b1, r, c);
      chk("b_row_idx", 128'(b_out_idx), 128'(r));
      chk("b_row_data", 128'(b_out_row), 128'(row2));
      @(negedge clk);
    end
    chk("b_done", 128'(b_done), 128'(1));
    b_out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_arr_os.md
Name: sys_arr_os

Overview:
- Parametrised output-stationary systolic matrix-multiply array; next generation of the fixed 4x4 PE array.
- Adds configurable data and accumulator widths, signed/unsigned mode, and internal input skewing.
- Uses a valid/ready input stream with stall, an automatic flush, and a row-by-row result drain with backpressure.
- Computes C[r][c] = sum over k of A[k][r]*W[k][c] for k = 0..k_len-1; sits between the operand buffers and the result writeback path.

Parameters:
ROWS, 4, array rows (activation lanes), >=1
COLS, 4, array columns (weight lanes), >=1
DW, 8, operand width in bits
AW, 32, accumulator width in bits, >= 2*DW
KW, 16, width of the k_len counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  1-cycle start request; honoured only in IDLE
k_len  in  KW  number of input beats in the job; sampled at start
sgn  in  1  1 = signed operands; sampled at start
in_valid  in  1  input beat valid
in_ready  out  1  array accepts beat
in_a  in  ROWS*DW  activations; lane r at bits [r*DW +: DW]
in_w  in  COLS*DW  weights; lane c at bits [c*DW +: DW]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_row  out  COLS*AW  C[out_idx][c] at bits [c*AW +: AW]
out_idx  out  max(1,clog2(ROWS))  row index of out_row
busy  out  1  state != IDLE
done  out  1  1-cycle pulse after the last row is accepted

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all accumulators, skew registers and PE pipeline registers = 0; in_ready=0, out_valid=0, out_idx=0, out_row=0, busy=0, done=0.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE + start:
  - Clear all accumulators and skew/pipe registers; latch k_len and sgn; clear the beat counter.
  - Next state: LOAD if k_len>0; else DRAIN with all results 0.
- start is ignored outside IDLE; a job in progress is unaffected.
- Step enable ("step"):
  - LOAD: step = in_valid & in_ready.
  - FLUSH: step = 1.
  - All other states: step = 0. With step=0, every skew, pipe and accumulator register holds.
- in_ready = (state==LOAD).
- LOAD: after k_len accepted beats, go to FLUSH, or directly to DRAIN if ROWS+COLS-2 == 0.
- FLUSH: exactly ROWS+COLS-2 steps with zero operands injected, then DRAIN.
- Skew: activation lane r is delayed r steps and weight lane c is delayed c steps; lane 0 is undelayed.
- PE(r,c):
  - Registers its a input to the right and its w input downward, on step.
  - Accumulates acc <= acc + a_in*w_in on step. a_in/w_in come from the left/upper neighbour registers or from the skew outputs.
  - PE(r,c) therefore multiplies beat s-r-c at step s.
- Arithmetic:
  - Operands are sign-extended (sgn=1) or zero-extended (sgn=0) to 2*DW; product is 2*DW bits, extended to AW.
  - Accumulation wraps modulo 2^AW; no saturation.
- DRAIN:
  - out_valid=1, out_row = accumulators of row out_idx.
  - Row values and out_idx are held stable while out_ready=0.
  - On out_valid & out_ready: out_idx increments. After row ROWS-1 is accepted: state=IDLE, out_idx=0, done=1 for one cycle.
- Latency: the first out_valid occurs ROWS+COLS-1 cycles after the cycle of the last input handshake.
- done and a new start may coincide: the start in the cycle after done is honoured (state is IDLE).

Test Plan:
- 4x4, DW=8, unsigned, k_len=4, A=identity, W rows = [1 2 3 4]..[13 14 15 16], in_valid held 1 -> rows drained equal W rows; first out_valid 7 cycles after the 4th handshake; done pulses once.
- sgn=1, k_len=2, all a=-1 (0xFF), all w=127 -> every C = -254 (0xFFFFFF02); same data with sgn=0 -> every C = 2*255*127 = 64770.
- Backpressure/stall: in_valid toggling 1,0,1,0 and out_ready low for 3 cycles per row -> results identical to the unstalled run; out_row and out_idx stable during stalls.
- k_len=0 -> no in_ready; 4 rows of zeros drained; done asserted.
- Reset asserted mid-LOAD after 2 beats -> all outputs 0 immediately (async); a new job then gives the correct result with no residue from the aborted job.
- start pulsed during FLUSH/DRAIN -> ignored, result unchanged; ROWS=2, COLS=3 instance with k_len=5 random vectors -> output matches the reference model.
